// File: rtl/phy_rx_pkg.sv
// Shared receive-PHY constants: K-character codes, scrambler seed and lock-state encoding.
package phy_rx_pkg;

  localparam logic [7:0]  COM_H     = 8'hBC;  // K28.5
  localparam logic [7:0]  SKP_H     = 8'h1C;  // K28.0
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/lfsr_byte_step.sv
// Advances the x^16+x^5+x^4+x^3+1 Galois scrambler by eight bit-times in one cycle.
// Purely combinational; key[i] is the MSB seen before step i.
module lfsr_byte_step (
  input  logic [15:0] lfsr_in,
  output logic [7:0]  key,
  output logic [15:0] lfsr_out
);

  logic [15:0] l;

  always_comb begin
    l   = lfsr_in;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = l[15];
      l = {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1], l[0], l[15]};
    end
    lfsr_out = l;
  end

endmodule

// File: rtl/rx_descrambler.sv
// Gen1 receive descrambler behind the 8b/10b decoder: COM-based lock, error-run unlock,
// SKP ordered-set length tracking and a single registered output stage (1-cycle latency).
module rx_descrambler
  import phy_rx_pkg::*;
#(
  parameter bit          SCRAMBLE_EN = 1'b1,
  parameter logic [15:0] SEED        = LFSR_SEED,
  parameter int          ERR_LIMIT   = 4,
  parameter int          MAX_SKP     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_code_err,
  input  logic       in_disp_err,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_k,
  output logic       out_err,
  output logic       locked,
  output logic       skp_os_done,
  output logic [2:0] skp_os_len,
  output logic       skp_os_err
);

  lock_state_e state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_next;
  logic [7:0]  key;
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic [2:0]  skp_cnt_q, skp_cnt_d;
  logic        in_os_q, in_os_d;
  logic        is_com, is_skp, char_err, accept, os_close;
  logic [7:0]  data_d;

  lfsr_byte_step u_step (
    .lfsr_in  (lfsr_q),
    .key      (key),
    .lfsr_out (lfsr_next)
  );

  assign is_com   = in_k && (in_data == COM_H);
  assign is_skp   = in_k && (in_data == SKP_H);
  assign char_err = in_code_err | in_disp_err;
  // In HUNT only a clean COM gets through; it is the first character of the locked stream.
  assign accept   = in_valid && ((state_q == LOCKED) || (is_com && !char_err));
  assign data_d   = (!in_k && SCRAMBLE_EN) ? (in_data ^ key) : in_data;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    err_cnt_d = err_cnt_q;
    skp_cnt_d = skp_cnt_q;
    in_os_d   = in_os_q;
    os_close  = 1'b0;

    if (in_valid) begin
      if (is_com)       lfsr_d = SEED;
      else if (!is_skp) lfsr_d = lfsr_next;
    end

    if (accept) begin
      if (in_os_q && !is_skp) begin
        os_close = 1'b1;
        in_os_d  = 1'b0;
      end
      if (is_com) begin
        in_os_d   = 1'b1;
        skp_cnt_d = '0;
      end else if (is_skp && in_os_q && (skp_cnt_q != 3'd7)) begin
        skp_cnt_d = skp_cnt_q + 3'd1;
      end

      if (state_q == HUNT) begin
        state_d = LOCKED;
      end else if (char_err) begin
        if (err_cnt_q == 4'(ERR_LIMIT - 1)) begin
          state_d   = HUNT;
          err_cnt_d = '0;
          in_os_d   = 1'b0;
        end else begin
          err_cnt_d = err_cnt_q + 4'd1;
        end
      end else begin
        err_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      lfsr_q      <= SEED;
      err_cnt_q   <= '0;
      skp_cnt_q   <= '0;
      in_os_q     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_k       <= 1'b0;
      out_err     <= 1'b0;
      skp_os_done <= 1'b0;
      skp_os_len  <= '0;
      skp_os_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      err_cnt_q   <= err_cnt_d;
      skp_cnt_q   <= skp_cnt_d;
      in_os_q     <= in_os_d;
      out_valid   <= accept;
      skp_os_done <= os_close && (skp_cnt_q != 3'd0);
      skp_os_len  <= (os_close && (skp_cnt_q != 3'd0)) ? skp_cnt_q : 3'd0;
      skp_os_err  <= os_close && (int'(skp_cnt_q) > MAX_SKP);
      if (in_valid) begin
        out_data <= data_d;
        out_k    <= in_k;
        out_err  <= char_err;
      end
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
